snoop_bus_ctrl: RTL and testbench



---
 rtl/rv32i_types.sv | 35 +++
 rtl/snoop_bus_ctrl_arb.sv | 44 ++++
 rtl/snoop_bus_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared coherence-bus types: response codes, command encodings and snoop-bus FSM states.
// Also holds a small width helper used by the snoop bus blocks.
package rv32i_types;

   typedef enum logic [1:0] {
      BUS_RESP_NONE    = 2'b00,
      BUS_RESP_HIT     = 2'b01,
      BUS_RESP_MISS    = 2'b10,
      BUS_RESP_TIMEOUT = 2'b11
   } bus_resp_t;

   localparam int BUS_CMD_W = 3;

   typedef enum logic [BUS_CMD_W-1:0] {
      BUS_CMD_NOP  = 3'd0,
      BUS_CMD_RD   = 3'd1,
      BUS_CMD_RDX  = 3'd2,
      BUS_CMD_UPGR = 3'd3,
      BUS_CMD_WB   = 3'd4,
      BUS_CMD_INV  = 3'd5
   } bus_cmd_t;

   typedef enum logic [1:0] {
      SB_IDLE      = 2'd0,
      SB_BROADCAST = 2'd1,
      SB_COLLECT   = 2'd2,
      SB_RESPOND   = 2'd3
   } sb_state_t;

   // Index width that never collapses to zero bits for a single core.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snoop_bus_ctrl_arb.sv
// Combinational round-robin picker: grants the first requester at or after rr_ptr.
// The pointer register itself lives in the parent controller.
module snoop_rr_arbiter
   import rv32i_types::*;
#(
   parameter  int NUM_CORES = 2,
   localparam int IDX_W     = clog2_min1(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [NUM_CORES-1:0] win_oh,
   output logic [IDX_W-1:0]     win_idx,
   output logic                 any_valid
);

   int   dist_s;
   int   best_dist_s;
   int   best_idx_s;
   logic take_s;

   // Distance from the pointer decides priority; smallest distance among requesters wins.
   always_comb begin
      dist_s      = 0;
      best_dist_s = NUM_CORES;
      best_idx_s  = 0;
      take_s      = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         dist_s      = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_CORES - int'(rr_ptr));
         take_s      = req[i] && (dist_s < best_dist_s);
         best_idx_s  = take_s ? i : best_idx_s;
         best_dist_s = take_s ? dist_s : best_dist_s;
      end
   end

   always_comb begin
      any_valid = |req;
      win_idx   = IDX_W'(best_idx_s);
      win_oh    = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         win_oh[i] = any_valid && (best_idx_s == i);
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// N-core snoop bus controller: round-robin arbitration, snoop broadcast, variable-latency
// acknowledgement collection with timeout, and a merged response to the requester.
module snoop_bus_ctrl
   import rv32i_types::*;
#(
   parameter  int NUM_CORES = 2,
   parameter  int ADDR_W    = 32,
   parameter  int LINE_W    = 256,
   parameter  int CMD_W     = 3,
   parameter  int TIMEOUT   = 16,
   localparam int SRC_W     = clog2_min1(NUM_CORES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CORES-1:0]              req_valid,
   input  logic [NUM_CORES-1:0][ADDR_W-1:0]  req_addr,
   input  logic [NUM_CORES-1:0][CMD_W-1:0]   req_cmd,
   input  logic [NUM_CORES-1:0][LINE_W-1:0]  req_data,
   output logic [NUM_CORES-1:0]              grant,
   output logic                              bus_ready,
   output logic                              snoop_valid,
   output logic [SRC_W-1:0]                  snoop_src,
   output logic [ADDR_W-1:0]                 snoop_addr,
   output logic [CMD_W-1:0]                  snoop_cmd,
   output logic [LINE_W-1:0]                 snoop_data,
   input  logic [NUM_CORES-1:0]              snoop_ack,
   input  logic [NUM_CORES-1:0]              snoop_hit,
   input  logic [NUM_CORES-1:0]              snoop_supply,
   input  logic [NUM_CORES-1:0][LINE_W-1:0]  snoop_line,
   output logic [NUM_CORES-1:0]              resp_valid,
   output logic [1:0]                        resp_status,
   output logic [ADDR_W-1:0]                 resp_addr,
   output logic [LINE_W-1:0]                 resp_data
);

   localparam int TMR_W = clog2_min1(TIMEOUT + 1);

   sb_state_t                state_q, state_d;
   logic [NUM_CORES-1:0]     grant_q, grant_d;
   logic                     snoop_valid_q, snoop_valid_d;
   logic [SRC_W-1:0]         src_q, src_d;
   logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [CMD_W-1:0]         cmd_q, cmd_d;
   logic [LINE_W-1:0]        data_q, data_d;
   logic [NUM_CORES-1:0]     ack_mask_q, ack_mask_d;
   logic                     hit_q, hit_d;
   logic                     supplied_q, supplied_d;
   logic [LINE_W-1:0]        line_q, line_d;
   logic [TMR_W-1:0]         tmr_q, tmr_d;
   logic [NUM_CORES-1:0]     resp_valid_q, resp_valid_d;
   bus_resp_t                resp_status_q, resp_status_d;
   logic [ADDR_W-1:0]        resp_addr_q, resp_addr_d;
   logic [LINE_W-1:0]        resp_data_q, resp_data_d;

   logic [NUM_CORES-1:0]     arb_oh_s;
   logic [SRC_W-1:0]         arb_idx_s;
   logic                     arb_any_s;
   logic                     collecting_s;
   logic [NUM_CORES-1:0]     accept_s;
   logic [NUM_CORES-1:0]     mask_new_s;
   logic                     done_s;
   logic                     hit_new_s;
   logic [NUM_CORES-1:0]     supply_acc_s;
   logic [SRC_W-1:0]         sup_idx_s;
   logic                     supplied_new_s;
   logic [LINE_W-1:0]        line_new_s;
   logic [TMR_W-1:0]         tmr_inc_s;
   logic                     timeout_s;

   snoop_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .win_oh    (arb_oh_s),
      .win_idx   (arb_idx_s),
      .any_valid (arb_any_s)
   );

   // Only first acks from non-requesting cores count; the requester's own bit is pre-filled as done.
   always_comb begin
      collecting_s   = (state_q == SB_BROADCAST) || (state_q == SB_COLLECT);
      accept_s       = collecting_s ? (snoop_ack & ~grant_q & ~ack_mask_q) : '0;
      mask_new_s     = ack_mask_q | accept_s;
      done_s         = &(mask_new_s | grant_q);
      hit_new_s      = hit_q | (|(accept_s & snoop_hit));
      supply_acc_s   = accept_s & snoop_supply;
      supplied_new_s = supplied_q | (|supply_acc_s);
      line_new_s     = (!supplied_q && (|supply_acc_s)) ? snoop_line[sup_idx_s] : line_q;
      tmr_inc_s      = tmr_q + TMR_W'(1);
      timeout_s      = (TIMEOUT != 0) && (state_q == SB_COLLECT) && !done_s &&
                       (tmr_inc_s == TMR_W'(TIMEOUT));
   end

   always_comb begin
      sup_idx_s = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         sup_idx_s = supply_acc_s[i] ? SRC_W'(i) : sup_idx_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_IDLE:      state_d = arb_any_s ? SB_BROADCAST : SB_IDLE;
         SB_BROADCAST: state_d = done_s ? SB_RESPOND : SB_COLLECT;
         SB_COLLECT:   state_d = (done_s || timeout_s) ? SB_RESPOND : SB_COLLECT;
         SB_RESPOND:   state_d = SB_IDLE;
         default:      state_d = SB_IDLE;
      endcase
   end

   always_comb begin
      grant_d       = grant_q;
      snoop_valid_d = 1'b0;
      src_d         = src_q;
      rr_ptr_d      = rr_ptr_q;
      addr_d        = addr_q;
      cmd_d         = cmd_q;
      data_d        = data_q;
      ack_mask_d    = ack_mask_q;
      hit_d         = hit_q;
      supplied_d    = supplied_q;
      line_d        = line_q;
      tmr_d         = tmr_q;
      resp_valid_d  = '0;
      resp_status_d = BUS_RESP_NONE;
      resp_addr_d   = resp_addr_q;
      resp_data_d   = resp_data_q;
      case (state_q)
         SB_IDLE: begin
            if (arb_any_s) begin
               grant_d       = arb_oh_s;
               snoop_valid_d = 1'b1;
               src_d         = arb_idx_s;
               rr_ptr_d      = (arb_idx_s == SRC_W'(NUM_CORES - 1)) ? '0 : arb_idx_s + SRC_W'(1);
               addr_d        = req_addr[arb_idx_s];
               cmd_d         = req_cmd[arb_idx_s];
               data_d        = req_data[arb_idx_s];
               ack_mask_d    = '0;
               hit_d         = 1'b0;
               supplied_d    = 1'b0;
               line_d        = '0;
               tmr_d         = '0;
            end else begin
               grant_d = '0;
            end
         end
         SB_BROADCAST, SB_COLLECT: begin
            ack_mask_d = mask_new_s;
            hit_d      = hit_new_s;
            supplied_d = supplied_new_s;
            line_d     = line_new_s;
            tmr_d      = (state_q == SB_COLLECT) ? tmr_inc_s : tmr_q;
            // The response is registered on the same edge that leaves collection.
            if (timeout_s) begin
               resp_valid_d  = grant_q;
               resp_status_d = BUS_RESP_TIMEOUT;
               resp_addr_d   = addr_q;
               resp_data_d   = '0;
            end else if (done_s) begin
               resp_valid_d  = grant_q;
               resp_status_d = hit_new_s ? BUS_RESP_HIT : BUS_RESP_MISS;
               resp_addr_d   = addr_q;
               resp_data_d   = line_new_s;
            end else begin
               resp_valid_d = '0;
            end
         end
         SB_RESPOND: grant_d = '0;
         default:    grant_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q       <= '0;
         snoop_valid_q <= 1'b0;
         src_q         <= '0;
         rr_ptr_q      <= '0;
         addr_q        <= '0;
         cmd_q         <= '0;
         data_q        <= '0;
         ack_mask_q    <= '0;
         hit_q         <= 1'b0;
         supplied_q    <= 1'b0;
         line_q        <= '0;
         tmr_q         <= '0;
         resp_valid_q  <= '0;
         resp_status_q <= BUS_RESP_NONE;
         resp_addr_q   <= '0;
         resp_data_q   <= '0;
      end else begin
         grant_q       <= grant_d;
         snoop_valid_q <= snoop_valid_d;
         src_q         <= src_d;
         rr_ptr_q      <= rr_ptr_d;
         addr_q        <= addr_d;
         cmd_q         <= cmd_d;
         data_q        <= data_d;
         ack_mask_q    <= ack_mask_d;
         hit_q         <= hit_d;
         supplied_q    <= supplied_d;
         line_q        <= line_d;
         tmr_q         <= tmr_d;
         resp_valid_q  <= resp_valid_d;
         resp_status_q <= resp_status_d;
         resp_addr_q   <= resp_addr_d;
         resp_data_q   <= resp_data_d;
      end
   end

   assign grant       = grant_q;
   assign bus_ready   = (state_q == SB_IDLE);
   assign snoop_valid = snoop_valid_q;
   assign snoop_src   = src_q;
   assign snoop_addr  = addr_q;
   assign snoop_cmd   = cmd_q;
   assign snoop_data  = data_q;
   assign resp_valid  = resp_valid_q;
   assign resp_status = resp_status_q;
   assign resp_addr   = resp_addr_q;
   assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Bench for snoop_bus_ctrl: a transaction-level model predicts winner, response cycle,
// status and data from per-core ack schedules; random and directed transactions share it.
module tb_snoop_bus_ctrl;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int LW = 64;
   localparam int CW = 3;
   localparam int TO = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NC-1:0]             req_valid;
   logic [NC-1:0][AW-1:0]     req_addr;
   logic [NC-1:0][CW-1:0]     req_cmd;
   logic [NC-1:0][LW-1:0]     req_data;
   logic [NC-1:0]             grant;
   logic                      bus_ready;
   logic                      snoop_valid;
   logic [1:0]                snoop_src;
   logic [AW-1:0]             snoop_addr;
   logic [CW-1:0]             snoop_cmd;
   logic [LW-1:0]             snoop_data;
   logic [NC-1:0]             snoop_ack;
   logic [NC-1:0]             snoop_hit;
   logic [NC-1:0]             snoop_supply;
   logic [NC-1:0][LW-1:0]     snoop_line;
   logic [NC-1:0]             resp_valid;
   logic [1:0]                resp_status;
   logic [AW-1:0]             resp_addr;
   logic [LW-1:0]             resp_data;

   snoop_bus_ctrl #(
      .NUM_CORES(NC), .ADDR_W(AW), .LINE_W(LW), .CMD_W(CW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_cmd(req_cmd), .req_data(req_data),
      .grant(grant), .bus_ready(bus_ready),
      .snoop_valid(snoop_valid), .snoop_src(snoop_src), .snoop_addr(snoop_addr),
      .snoop_cmd(snoop_cmd), .snoop_data(snoop_data),
      .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .snoop_supply(snoop_supply),
      .snoop_line(snoop_line),
      .resp_valid(resp_valid), .resp_status(resp_status), .resp_addr(resp_addr),
      .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int            rr_ptr_m;
   logic [NC-1:0] pending;
   int            ack_dly [NC];
   bit            ack_hit [NC];
   bit            ack_sup [NC];
   logic [LW-1:0] ack_line [NC];
   bit            noise_en;
   bit            self_ack;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom(), $urandom()};
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a);
      pending[i]  = 1'b1;
      req_addr[i] = a;
      req_cmd[i]  = CW'($urandom());
      req_data[i] = rand_line();
   endtask

   task automatic sched_plain();
      for (int j = 0; j < NC; j++) begin
         ack_dly[j]  = 0;
         ack_hit[j]  = 1'b0;
         ack_sup[j]  = 1'b0;
         ack_line[j] = rand_line();
      end
      noise_en = 1'b0;
      self_ack = 1'b0;
   endtask

   task automatic sched_rand();
      for (int j = 0; j < NC; j++) begin
         ack_dly[j]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
         ack_hit[j]  = ($urandom_range(0, 3) == 0);
         ack_sup[j]  = ($urandom_range(0, 2) == 0);
         ack_line[j] = rand_line();
      end
      noise_en = 1'b1;
      self_ack = 1'b0;
   endtask

   task automatic scramble_snoop();
      snoop_hit    = NC'($urandom());
      snoop_supply = NC'($urandom());
      for (int j = 0; j < NC; j++) snoop_line[j] = rand_line();
   endtask

   // Called at a negedge with the bus idle; runs one full transaction and checks it.
   task automatic run_txn();
      int            w;
      int            d_max;
      int            best;
      int            r_rel;
      int            dj;
      bit            never;
      bit            exp_hit;
      logic [1:0]    exp_st;
      logic [LW-1:0] exp_data;
      logic [AW-1:0] exp_addr;
      logic [CW-1:0] exp_cmd;
      logic [LW-1:0] exp_rd;
      logic [NC-1:0] og;

      chk("idle_ready", 64'(bus_ready), 64'(1));
      chk("idle_grant", 64'(grant), 64'(0));
      chk("idle_resp", 64'(resp_valid), 64'(0));
      scramble_snoop();
      snoop_ack = noise_en ? NC'($urandom()) : '0;
      req_valid = pending;

      w = -1;
      for (int k = 0; k < NC; k++) begin
         if (w < 0 && pending[(rr_ptr_m + k) % NC]) w = (rr_ptr_m + k) % NC;
      end
      exp_addr = req_addr[w];
      exp_cmd  = req_cmd[w];
      exp_rd   = req_data[w];
      rr_ptr_m = (w + 1) % NC;
      og       = '0;
      og[w]    = 1'b1;

      never = 1'b0; d_max = 0; best = -1; exp_hit = 1'b0;
      for (int j = 0; j < NC; j++) begin
         if (j != w) begin
            if (ack_dly[j] < 0) never = 1'b1;
            else begin
               if (ack_dly[j] > d_max) d_max = ack_dly[j];
               if (ack_hit[j]) exp_hit = 1'b1;
               if (ack_sup[j] && (best < 0 || ack_dly[j] < ack_dly[best])) best = j;
            end
         end
      end
      if (never || d_max > TO) begin
         r_rel    = TO + 1;
         exp_st   = 2'b11;
         exp_data = '0;
      end else begin
         r_rel    = d_max + 1;
         exp_st   = exp_hit ? 2'b01 : 2'b10;
         exp_data = (best >= 0) ? ack_line[best] : '0;
      end

      @(negedge clk);
      chk("grant", 64'(grant), 64'(og));
      chk("snoop_valid", 64'(snoop_valid), 64'(1));
      chk("snoop_src", 64'(snoop_src), 64'(w));
      chk("snoop_addr", 64'(snoop_addr), 64'(exp_addr));
      chk("snoop_cmd", 64'(snoop_cmd), 64'(exp_cmd));
      chk("snoop_data", 64'(snoop_data), 64'(exp_rd));
      chk("busy", 64'(bus_ready), 64'(0));

      for (int c = 0; c < r_rel; c++) begin
         snoop_ack = '0;
         scramble_snoop();
         for (int j = 0; j < NC; j++) begin
            if (j != w && ack_dly[j] == c) begin
               snoop_ack[j]    = 1'b1;
               snoop_hit[j]    = ack_hit[j];
               snoop_supply[j] = ack_sup[j];
               snoop_line[j]   = ack_line[j];
            end
         end
         if ((self_ack && c == 1) || (noise_en && $urandom_range(0, 3) == 0)) begin
            snoop_ack[w] = 1'b1; snoop_hit[w] = 1'b1; snoop_supply[w] = 1'b1;
         end
         dj = int'($urandom_range(0, NC - 1));
         if (noise_en && dj != w && ack_dly[dj] >= 0 && ack_dly[dj] < c) begin
            snoop_ack[dj] = 1'b1; snoop_hit[dj] = 1'b1; snoop_supply[dj] = 1'b1;
         end
         if (noise_en && c == 1 && $urandom_range(0, 3) == 0) req_valid[w] = 1'b0;
         @(negedge clk);
         if (c < r_rel - 1) begin
            chk("early_resp", 64'(resp_valid), 64'(0));
            chk("strobe_len", 64'(snoop_valid), 64'(0));
         end
      end

      chk("resp_valid", 64'(resp_valid), 64'(og));
      chk("resp_status", 64'(resp_status), 64'(exp_st));
      chk("resp_addr", 64'(resp_addr), 64'(exp_addr));
      chk("resp_data", 64'(resp_data), 64'(exp_data));
      snoop_ack  = '0;
      pending[w] = 1'b0;
      req_valid  = pending;

      @(negedge clk);
      chk("post_resp", 64'(resp_valid), 64'(0));
      chk("post_grant", 64'(grant), 64'(0));
      chk("post_ready", 64'(bus_ready), 64'(1));
   endtask

   initial begin
      rst = 1'b0;
      req_valid = '0; req_addr = '0; req_cmd = '0; req_data = '0;
      snoop_ack = '0; snoop_hit = '0; snoop_supply = '0; snoop_line = '0;
      rr_ptr_m = 0; pending = '0;
      sched_plain();

      #2;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_snoop_valid", 64'(snoop_valid), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_status", 64'(resp_status), 64'(0));
      chk("rst_ready", 64'(bus_ready), 64'(1));
      chk("rst_snoop_addr", 64'(snoop_addr), 64'(0));
      chk("rst_resp_data", 64'(resp_data), 64'(0));
      @(negedge clk);
      rst = 1'b1;

      // Every core requesting: grants must rotate 0,1,2,3,0.
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < NC; i++) if (!pending[i]) set_req(i, AW'($urandom()));
         sched_plain();
         run_txn();
      end
      pending = '0;

      // Same-cycle hit with supplied line.
      set_req(0, 32'h0000_1040);
      sched_plain();
      ack_hit[1] = 1'b1; ack_sup[1] = 1'b1; ack_line[1] = {8{8'hAA}};
      run_txn();

      // Staggered misses finishing exactly at the timeout limit, plus a self-ack.
      set_req(2, AW'($urandom()));
      sched_plain();
      ack_dly[0] = 0; ack_dly[1] = 2; ack_dly[3] = 4;
      self_ack = 1'b1;
      run_txn();

      // Missing ack forces a timeout.
      set_req(0, AW'($urandom()));
      sched_plain();
      ack_dly[1] = -1;
      ack_hit[2] = 1'b1; ack_sup[2] = 1'b1;
      run_txn();

      // Simultaneous supply: lowest index wins; a later supplier is ignored.
      set_req(0, AW'($urandom()));
      sched_plain();
      ack_dly[1] = 1; ack_sup[1] = 1'b1;
      ack_dly[3] = 1; ack_sup[3] = 1'b1; ack_hit[3] = 1'b1;
      ack_dly[2] = 2; ack_sup[2] = 1'b1;
      run_txn();

      // Reset in the middle of collection.
      set_req(2, AW'($urandom()));
      req_valid = pending;
      snoop_ack = '0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_grant", 64'(grant), 64'(0));
      chk("mid_rst_resp", 64'(resp_valid), 64'(0));
      chk("mid_rst_ready", 64'(bus_ready), 64'(1));
      chk("mid_rst_snoop_addr", 64'(snoop_addr), 64'(0));
      chk("mid_rst_src", 64'(snoop_src), 64'(0));
      @(negedge clk);
      chk("mid_rst_resp2", 64'(resp_valid), 64'(0));
      rst = 1'b1;
      rr_ptr_m = 0;
      pending = '0;
      set_req(1, AW'($urandom()));
      set_req(3, AW'($urandom()));
      sched_plain();
      run_txn();

      // Random traffic with stray, duplicate and self acks.
      for (int t = 0; t < 80; t++) begin
         for (int i = 0; i < NC; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) set_req(i, AW'($urandom()));
         end
         if (pending == '0) begin
            req_valid = '0;
            snoop_ack = '0;
            @(negedge clk);
            chk("idle_hold", 64'(grant), 64'(0));
            set_req(int'($urandom_range(0, NC - 1)), AW'($urandom()));
         end
         sched_rand();
         run_txn();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
